// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Shared types and helpers for the UART RX frame checker.
//   - state_t           : frame checker FSM states
//   - PAR_EVEN/PAR_ODD  : encodings of the par_typ configuration input
//   - MAX_DATA_WIDTH    : widest supported data word (used to pad parity input)
//   - bit_cnt_width()   : width of a counter able to hold 0..n
//   - expected_parity() : parity bit the transmitter should have sent
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MAX_DATA_WIDTH = 9;

    function automatic int bit_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Zero padding above the real data width does not change the XOR reduction.
    function automatic logic expected_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                             input logic                      typ);
        if (typ == PAR_ODD) begin
            return ~^data;
        end else begin
            return ^data;
        end
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// uart_rx_frame_check_if
//   Bundles the sampler-side inputs and the frame-result outputs of the
//   UART RX frame checker.
//   master : the sampler/consumer side (drives frame_start, bit_valid,
//            sampled_bit, config and cnt_clr; observes results)
//   slave  : the frame checker itself
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);

    logic                  frame_start;
    logic                  bit_valid;
    logic                  sampled_bit;
    logic                  par_en;
    logic                  par_typ;
    logic                  stop2;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  frame_done;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;

    modport master (
        output frame_start, bit_valid, sampled_bit, par_en, par_typ, stop2, cnt_clr,
        input  rx_data, frame_done, data_valid, par_err, stp_err, busy,
               par_err_cnt, stp_err_cnt
    );

    modport slave (
        input  frame_start, bit_valid, sampled_bit, par_en, par_typ, stop2, cnt_clr,
        output rx_data, frame_done, data_valid, par_err, stp_err, busy,
               par_err_cnt, stp_err_cnt
    );

endinterface

// File: rtl/uart_err_counter.sv
// uart_err_counter
//   Saturating event counter. Clear has priority over a same-cycle increment.
//   CLK   in  system clock
//   RST   in  synchronous active-low reset
//   inc   in  count one event (ignored at all-ones)
//   clr   in  force count to zero
//   count out current count
module uart_err_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_r;

    // Count register: clear beats increment, increment stops at all-ones.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_WIDTH{1'b1}})) begin
            count_r <= count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check
//   UART RX frame checker: deserialises DATA_WIDTH bits LSB-first, checks an
//   optional even/odd parity bit and one or two stop bits, and keeps
//   saturating parity/stop error counters.
//   CLK  in     system clock, all logic on posedge
//   RST  in     synchronous active-low reset
//   rx   slave  frame_start/bit_valid/sampled_bit/config/cnt_clr in;
//               rx_data, frame_done, data_valid, par_err, stp_err, busy,
//               par_err_cnt, stp_err_cnt out (all registered)
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_frame_check_if.slave  rx
);

    localparam int                BCW      = bit_cnt_width(DATA_WIDTH);
    localparam logic [BCW-1:0]    LAST_BIT = BCW'(DATA_WIDTH - 1);

    state_t                      state_r;
    state_t                      state_s;
    logic [BCW-1:0]              bit_cnt_r;
    logic [DATA_WIDTH-1:0]       shift_r;
    logic                        par_en_r;
    logic                        par_typ_r;
    logic                        stop2_r;
    logic                        frame_par_err_r;
    logic                        frame_stp_err_r;

    logic [DATA_WIDTH-1:0]       rx_data_r;
    logic                        frame_done_r;
    logic                        data_valid_r;
    logic                        par_err_r;
    logic                        stp_err_r;
    logic                        busy_r;

    logic [MAX_DATA_WIDTH-1:0]   shift_pad_s;
    logic                        par_exp_s;
    logic                        stp_final_s;
    logic                        finish_s;
    logic [CNT_WIDTH-1:0]        par_cnt_s;
    logic [CNT_WIDTH-1:0]        stp_cnt_s;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; frame_start restarts from any state and hides a same-cycle bit.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else if (rx.bit_valid && (bit_cnt_r == LAST_BIT)) begin
                    state_s = par_en_r ? PARITY : STOP1;
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else if (rx.bit_valid) begin
                    state_s = STOP1;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP1: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else if (rx.bit_valid) begin
                    state_s = stop2_r ? STOP2 : DONE;
                end else begin
                    state_s = STOP1;
                end
            end
            STOP2: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else if (rx.bit_valid) begin
                    state_s = DONE;
                end else begin
                    state_s = STOP2;
                end
            end
            DONE: begin
                if (rx.frame_start) begin
                    state_s = DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath helpers: padded parity input, stop flag including the current bit,
    // and the edge that moves the FSM into DONE (only reachable from a stop state).
    always_comb begin
        shift_pad_s                 = '0;
        shift_pad_s[DATA_WIDTH-1:0] = shift_r;
        par_exp_s                   = expected_parity(shift_pad_s, par_typ_r);
        stp_final_s                 = frame_stp_err_r | ~rx.sampled_bit;
        finish_s                    = (state_s == DONE);
    end

    // Frame datapath and registered results; results load on the edge entering DONE
    // so they are visible during the DONE cycle and hold until the next frame ends.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            bit_cnt_r       <= '0;
            shift_r         <= '0;
            par_en_r        <= 1'b0;
            par_typ_r       <= 1'b0;
            stop2_r         <= 1'b0;
            frame_par_err_r <= 1'b0;
            frame_stp_err_r <= 1'b0;
            rx_data_r       <= '0;
            frame_done_r    <= 1'b0;
            data_valid_r    <= 1'b0;
            par_err_r       <= 1'b0;
            stp_err_r       <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            if (rx.frame_start) begin
                par_en_r        <= rx.par_en;
                par_typ_r       <= rx.par_typ;
                stop2_r         <= rx.stop2;
                bit_cnt_r       <= '0;
                shift_r         <= '0;
                frame_par_err_r <= 1'b0;
                frame_stp_err_r <= 1'b0;
            end else if (rx.bit_valid) begin
                case (state_r)
                    DATA: begin
                        shift_r   <= {rx.sampled_bit, shift_r[DATA_WIDTH-1:1]};
                        bit_cnt_r <= bit_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
                    end
                    PARITY: begin
                        frame_par_err_r <= (rx.sampled_bit != par_exp_s);
                    end
                    STOP1, STOP2: begin
                        frame_stp_err_r <= stp_final_s;
                    end
                    default: begin
                        shift_r <= shift_r;
                    end
                endcase
            end else begin
                shift_r <= shift_r;
            end

            frame_done_r <= finish_s;
            data_valid_r <= finish_s & ~(frame_par_err_r | stp_final_s);
            if (finish_s) begin
                rx_data_r <= shift_r;
                par_err_r <= frame_par_err_r;
                stp_err_r <= stp_final_s;
            end else begin
                rx_data_r <= rx_data_r;
            end
            busy_r <= (state_s != IDLE);
        end
    end

    // Counters step at the end of the DONE cycle, from the already-registered flags.
    uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   ((state_r == DONE) && par_err_r),
        .clr   (rx.cnt_clr),
        .count (par_cnt_s)
    );

    uart_err_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   ((state_r == DONE) && stp_err_r),
        .clr   (rx.cnt_clr),
        .count (stp_cnt_s)
    );

    assign rx.rx_data     = rx_data_r;
    assign rx.frame_done  = frame_done_r;
    assign rx.data_valid  = data_valid_r;
    assign rx.par_err     = par_err_r;
    assign rx.stp_err     = stp_err_r;
    assign rx.busy        = busy_r;
    assign rx.par_err_cnt = par_cnt_s;
    assign rx.stp_err_cnt = stp_cnt_s;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check
//   Directed testbench for uart_rx_frame_check (DATA_WIDTH=8, CNT_WIDTH=2).
//   Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_uart_rx_frame_check;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks      = 0;
    int   failures    = 0;
    int   done_pulses = 0;
    int   snap        = 0;

    uart_rx_frame_check_if #(.DATA_WIDTH(8), .CNT_WIDTH(2)) rx ();

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (rx)
    );

    always #5 CLK = ~CLK;

    // Count every frame_done pulse seen by the bench.
    always @(negedge CLK) begin
        if (rx.frame_done === 1'b1) begin
            done_pulses <= done_pulses + 1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        rx.bit_valid   = 1'b1;
        rx.sampled_bit = b;
        tick();
        rx.bit_valid   = 1'b0;
        rx.sampled_bit = 1'b0;
    endtask

    task automatic start_frame();
        rx.frame_start = 1'b1;
        tick();
        rx.frame_start = 1'b0;
    endtask

    // Full frame using the current config pins; returns in the DONE cycle.
    task automatic send_frame(input logic [7:0] data, input logic par, input logic s1, input logic s2);
        start_frame();
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
        end
        if (rx.par_en) begin
            send_bit(par);
        end
        send_bit(s1);
        if (rx.stop2) begin
            send_bit(s2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx.frame_start = 1'b0;
        rx.bit_valid   = 1'b0;
        rx.sampled_bit = 1'b0;
        rx.par_en      = 1'b0;
        rx.par_typ     = 1'b0;
        rx.stop2       = 1'b0;
        rx.cnt_clr     = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();

        // Reset state
        check_value("rst_busy",    32'(rx.busy),        32'd0);
        check_value("rst_done",    32'(rx.frame_done),  32'd0);
        check_value("rst_data",    32'(rx.rx_data),     32'd0);
        check_value("rst_par_cnt", 32'(rx.par_err_cnt), 32'd0);

        // 1: 8N1 frame 0xA5
        start_frame();
        check_value("t1_busy", 32'(rx.busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'(8'hA5 >> i));
        end
        check_value("t1_pre_done", 32'(rx.frame_done), 32'd0);
        send_bit(1'b1);
        check_value("t1_done",    32'(rx.frame_done), 32'd1);
        check_value("t1_valid",   32'(rx.data_valid), 32'd1);
        check_value("t1_data",    32'(rx.rx_data),    32'hA5);
        check_value("t1_par_err", 32'(rx.par_err),    32'd0);
        check_value("t1_stp_err", 32'(rx.stp_err),    32'd0);
        tick();
        check_value("t1_done_pulse", 32'(rx.frame_done), 32'd0);
        check_value("t1_idle",       32'(rx.busy),       32'd0);
        check_value("t1_hold",       32'(rx.rx_data),    32'hA5);

        // 2: even parity 0x03 good then bad, then odd parity 0x07 good
        rx.par_en  = 1'b1;
        rx.par_typ = 1'b0;
        send_frame(8'h03, 1'b0, 1'b1, 1'b1);
        check_value("t2_even_ok_valid", 32'(rx.data_valid), 32'd1);
        check_value("t2_even_ok_perr",  32'(rx.par_err),    32'd0);
        check_value("t2_even_ok_data",  32'(rx.rx_data),    32'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check_value("t2_bad_done",  32'(rx.frame_done), 32'd1);
        check_value("t2_bad_perr",  32'(rx.par_err),    32'd1);
        check_value("t2_bad_valid", 32'(rx.data_valid), 32'd0);
        tick();
        check_value("t2_par_cnt", 32'(rx.par_err_cnt), 32'd1);
        rx.par_typ = 1'b1;
        send_frame(8'h07, 1'b0, 1'b1, 1'b1);
        check_value("t2_odd_ok_valid", 32'(rx.data_valid), 32'd1);
        check_value("t2_odd_ok_data",  32'(rx.rx_data),    32'h07);
        tick();

        // 3: two stop bits
        rx.par_en = 1'b0;
        rx.stop2  = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_value("t3_stp_err", 32'(rx.stp_err),    32'd1);
        check_value("t3_valid",   32'(rx.data_valid), 32'd0);
        check_value("t3_data",    32'(rx.rx_data),    32'h5A);
        tick();
        check_value("t3_stp_cnt", 32'(rx.stp_err_cnt), 32'd1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check_value("t3_good_stp",   32'(rx.stp_err),    32'd0);
        check_value("t3_good_valid", 32'(rx.data_valid), 32'd1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        check_value("t3_first_stop_bad", 32'(rx.stp_err), 32'd1);
        tick();
        check_value("t3_stp_cnt2", 32'(rx.stp_err_cnt), 32'd2);

        // 4: saturation at 3 and clear beating a same-cycle increment
        rx.cnt_clr = 1'b1;
        tick();
        rx.cnt_clr = 1'b0;
        check_value("t4_clr_par", 32'(rx.par_err_cnt), 32'd0);
        check_value("t4_clr_stp", 32'(rx.stp_err_cnt), 32'd0);
        rx.par_en  = 1'b1;
        rx.par_typ = 1'b0;
        rx.stop2   = 1'b0;
        for (int f = 0; f < 5; f++) begin
            send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        end
        tick();
        check_value("t4_saturated", 32'(rx.par_err_cnt), 32'd3);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check_value("t4_sixth_perr", 32'(rx.par_err), 32'd1);
        rx.cnt_clr = 1'b1;
        tick();
        rx.cnt_clr = 1'b0;
        check_value("t4_clr_wins", 32'(rx.par_err_cnt), 32'd0);
        tick();

        // 5: abort after 4 bits, restart with a coincident bit_valid, frame 0x3C
        rx.par_en = 1'b0;
        rx.stop2  = 1'b0;
        snap = done_pulses;
        start_frame();
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
        end
        rx.frame_start = 1'b1;
        rx.bit_valid   = 1'b1;
        rx.sampled_bit = 1'b1;
        tick();
        rx.frame_start = 1'b0;
        rx.bit_valid   = 1'b0;
        rx.sampled_bit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'(8'h3C >> i));
        end
        send_bit(1'b1);
        check_value("t5_data",  32'(rx.rx_data),    32'h3C);
        check_value("t5_valid", 32'(rx.data_valid), 32'd1);
        tick();
        tick();
        check_value("t5_one_done", 32'(done_pulses - snap), 32'd1);
        check_value("t5_par_cnt",  32'(rx.par_err_cnt),     32'd0);
        check_value("t5_stp_cnt",  32'(rx.stp_err_cnt),     32'd0);

        // 6: reset during STOP1 clears everything; bit_valid in IDLE is ignored
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check_value("t6_pre_stp", 32'(rx.stp_err), 32'd1);
        tick();
        check_value("t6_pre_cnt", 32'(rx.stp_err_cnt), 32'd1);
        rx.stop2 = 1'b1;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
        end
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check_value("t6_busy",  32'(rx.busy),        32'd0);
        check_value("t6_data",  32'(rx.rx_data),     32'd0);
        check_value("t6_stp",   32'(rx.stp_err),     32'd0);
        check_value("t6_cnt",   32'(rx.stp_err_cnt), 32'd0);
        check_value("t6_done",  32'(rx.frame_done),  32'd0);
        snap = done_pulses;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1);
        end
        tick();
        check_value("t6_idle_bits", 32'(done_pulses - snap), 32'd0);
        check_value("t6_idle_busy", 32'(rx.busy),            32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
